// File: rtl/sram_bridge_pkg.sv
// ---------------------------------------------------------------------------
// sram_bridge_pkg
// Shared definitions for sram_bus_bridge:
//   state_e     - bridge FSM state encoding
//   READ_FILL   - value returned to the CPU when a read times out
//   lane_e      - byte-lane select within a 16-bit SRAM word (packed mapping)
//   merge_lane  - replace one byte lane of a word
//   pick_lane   - extract one byte lane of a word
// ---------------------------------------------------------------------------
package sram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR_RD = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [7:0] READ_FILL = 8'hFF;

    // Odd CPU byte addresses live in the high byte of the SRAM word.
    typedef enum logic {
        LANE_LO = 1'b0,
        LANE_HI = 1'b1
    } lane_e;

    function automatic logic [15:0] merge_lane(input logic [15:0] word,
                                               input logic [7:0]  data,
                                               input lane_e       lane);
        logic [15:0] merged;
        merged = word;
        if (lane == LANE_HI) begin
            merged[15:8] = data;
        end else begin
            merged[7:0] = data;
        end
        return merged;
    endfunction

    function automatic logic [7:0] pick_lane(input logic [15:0] word,
                                             input lane_e       lane);
        return (lane == LANE_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sram_bus_bridge.sv
// ---------------------------------------------------------------------------
// sram_bus_bridge
// Bridges an 8-bit CPU RAM port (level requests, ready handshake) onto a
// 16-bit SRAM controller that takes single-cycle command strobes and answers
// with mem_ready. A wait counter aborts accesses the controller never
// completes and raises a sticky bus_err.
//
// Build option: define SRAM_BRIDGE_PACKED_EN for packed mapping (two CPU
// bytes per SRAM word, byte writes by read-modify-write). Without it, each
// CPU byte occupies the low byte of its own SRAM word.
//
// Parameters:
//   TIMEOUT_CYCLES  memory-wait cycles counted from the strobe before abort
//                   (2..255)
// Ports:
//   clk             clock
//   reset_n         asynchronous active-low reset
//   cpu_addr        CPU byte address (stable while cpu_ready is low)
//   cpu_do          CPU write data
//   cpu_read        CPU read request (level)
//   cpu_write       CPU write request (level, wins over cpu_read)
//   cpu_ready       ready to the CPU (combinational)
//   cpu_di          registered read data to the CPU
//   mem_address     SRAM word address
//   mem_data_write  SRAM write data
//   mem_read        one-cycle read command strobe
//   mem_write       one-cycle write command strobe
//   mem_ready       controller completion
//   mem_data_read   controller read data, valid with mem_ready
//   bus_err         sticky timeout flag
// ---------------------------------------------------------------------------
module sram_bus_bridge
    import sram_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic        cpu_ready,
    output logic [7:0]  cpu_di,
    output logic [17:0] mem_address,
    output logic [15:0] mem_data_write,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    input  logic [15:0] mem_data_read,
    output logic        bus_err
);

    // The counter is 0 in the strobe cycle, so an access that has seen
    // TIMEOUT_CYCLES-1 further cycles without completion is abandoned and
    // DONE lands exactly TIMEOUT_CYCLES cycles after the strobe.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [7:0]  cpu_di_q, cpu_di_d;
    logic [17:0] mem_address_q, mem_address_d;
    logic [15:0] mem_data_write_q, mem_data_write_d;
    logic        bus_err_q, bus_err_d;

`ifdef SRAM_BRIDGE_PACKED_EN
    lane_e       lane_q, lane_d;
    logic [7:0]  wbyte_q, wbyte_d;
`else
    // Linear mapping only returns the low byte of each word.
    logic        unused_hi_byte;
    assign unused_hi_byte = ^mem_data_read[15:8];
`endif

    logic request;
    logic strobe_cycle;
    logic mem_done;
    logic timed_out;

    assign request      = cpu_read | cpu_write;
    assign strobe_cycle = mem_read_q | mem_write_q;
    // A completion coinciding with our own strobe cannot belong to it, so it
    // is ignored; this also keeps read latency at three cycles minimum.
    assign mem_done     = mem_ready & ~strobe_cycle;
    assign timed_out    = ~mem_done & (cnt_q == TIMEOUT_LAST);

    assign cpu_ready      = ((state_q == ST_IDLE) && !request) || (state_q == ST_DONE);
    assign cpu_di         = cpu_di_q;
    assign mem_address    = mem_address_q;
    assign mem_data_write = mem_data_write_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign bus_err        = bus_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            cpu_di_q         <= 8'h00;
            mem_address_q    <= '0;
            mem_data_write_q <= '0;
            bus_err_q        <= 1'b0;
`ifdef SRAM_BRIDGE_PACKED_EN
            lane_q           <= LANE_LO;
            wbyte_q          <= 8'h00;
`endif
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            cpu_di_q         <= cpu_di_d;
            mem_address_q    <= mem_address_d;
            mem_data_write_q <= mem_data_write_d;
            bus_err_q        <= bus_err_d;
`ifdef SRAM_BRIDGE_PACKED_EN
            lane_q           <= lane_d;
            wbyte_q          <= wbyte_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        cpu_di_d         = cpu_di_q;
        mem_address_d    = mem_address_q;
        mem_data_write_d = mem_data_write_q;
        bus_err_d        = bus_err_q;
`ifdef SRAM_BRIDGE_PACKED_EN
        lane_d           = lane_q;
        wbyte_d          = wbyte_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    cnt_d = '0;
`ifdef SRAM_BRIDGE_PACKED_EN
                    mem_address_d = {3'b000, cpu_addr[15:1]};
                    lane_d        = lane_e'(cpu_addr[0]);
                    wbyte_d       = cpu_do;
                    // Byte writes must fetch the partner byte first.
                    state_d       = cpu_write ? ST_WR_RD : ST_RD;
                    mem_read_d    = 1'b1;
`else
                    mem_address_d = {2'b00, cpu_addr};
                    if (cpu_write) begin
                        mem_data_write_d = {8'h00, cpu_do};
                        state_d          = ST_WR;
                        mem_write_d      = 1'b1;
                    end else begin
                        state_d    = ST_RD;
                        mem_read_d = 1'b1;
                    end
`endif
                end
            end

            ST_RD: begin
                if (mem_done) begin
`ifdef SRAM_BRIDGE_PACKED_EN
                    cpu_di_d = pick_lane(mem_data_read, lane_q);
`else
                    cpu_di_d = mem_data_read[7:0];
`endif
                    state_d = ST_DONE;
                end else if (timed_out) begin
                    cpu_di_d  = READ_FILL;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_WR_RD: begin
`ifdef SRAM_BRIDGE_PACKED_EN
                if (mem_done) begin
                    mem_data_write_d = merge_lane(mem_data_read, wbyte_q, lane_q);
                    state_d          = ST_WR;
                    mem_write_d      = 1'b1;
                    cnt_d            = '0;
                end else if (timed_out) begin
                    // Abandon the whole write: no write strobe follows.
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            ST_WR: begin
                if (mem_done) begin
                    state_d = ST_DONE;
                end else if (timed_out) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_bus_bridge.sv
module tb_sram_bus_bridge;

    localparam int TMO = 8;
`ifdef SRAM_BRIDGE_PACKED_EN
    localparam bit PACKED = 1'b1;
`else
    localparam bit PACKED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_do;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_ready;
    logic [7:0]  cpu_di;
    logic [17:0] mem_address;
    logic [15:0] mem_data_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready;
    logic [15:0] mem_data_read;
    logic        bus_err;

    int total  = 0;
    int passed = 0;

    // Behavioural state: SRAM contents, expected sticky error, last CPU data.
    logic [15:0] mem [logic [17:0]];
    logic        err_exp;
    logic [7:0]  last_di;

    sram_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cpu_addr(cpu_addr),
        .cpu_do(cpu_do),
        .cpu_read(cpu_read),
        .cpu_write(cpu_write),
        .cpu_ready(cpu_ready),
        .cpu_di(cpu_di),
        .mem_address(mem_address),
        .mem_data_write(mem_data_write),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_ready(mem_ready),
        .mem_data_read(mem_data_read),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] mem_word(input logic [17:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    // One CPU access, with the bench acting as the SRAM controller.
    // dly: cycles from strobe to mem_ready; respond=0 never answers.
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [7:0] data, input int dly, input bit respond);
        logic [17:0] waddr;
        logic [15:0] word;
        logic [15:0] exp_w;
        logic [7:0]  exp_di;
        int exp_rd, exp_wr, n, pend, nrd, nwr, since, first_n;
        bit done, addr_ok;

        waddr = PACKED ? {3'b000, addr[15:1]} : {2'b00, addr};
        word  = mem_word(waddr);
        exp_w = 16'h0000;
        exp_di = last_di;
        if (!wr) begin
            exp_rd = 1; exp_wr = 0;
            if (!respond)                exp_di = 8'hFF;
            else if (PACKED && addr[0])  exp_di = word[15:8];
            else                         exp_di = word[7:0];
        end else if (PACKED) begin
            exp_rd = 1; exp_wr = respond ? 1 : 0;
            exp_w  = addr[0] ? {data, word[7:0]} : {word[15:8], data};
        end else begin
            exp_rd = 0; exp_wr = 1;
            exp_w  = {8'h00, data};
        end
        if (!respond) err_exp = 1'b1;

        @(negedge clk);
        cpu_addr = addr; cpu_do = data; cpu_read = rd; cpu_write = wr; mem_ready = 1'b0;
        #1 chk("req_ready_low", {31'd0, cpu_ready}, 32'd0);

        n = 0; pend = -1; nrd = 0; nwr = 0; since = 0; first_n = -1; done = 0; addr_ok = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++; since++;
            mem_ready = 1'b0;
            if (mem_read === 1'b1 || mem_write === 1'b1) begin
                if (first_n < 0) first_n = n;
                since = 0;
                if (mem_read === 1'b1)  nrd++;
                if (mem_write === 1'b1) nwr++;
                chk("strobe_addr", {14'd0, mem_address}, {14'd0, waddr});
                if (mem_write === 1'b1) chk("wr_data", {16'd0, mem_data_write}, {16'd0, exp_w});
                pend = respond ? dly : -1;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_ready     = 1'b1;
                    mem_data_read = mem_word(waddr);
                    if (nwr > 0) mem[waddr] = exp_w;
                    pend = -1;
                end
            end
            if (first_n >= 0 && cpu_ready !== 1'b1 && mem_address !== waddr) addr_ok = 0;
            if (cpu_ready === 1'b1) done = 1;
        end

        chk("done_reached", {31'd0, done}, 32'd1);
        chk("strobe_first_edge", first_n, 1);
        chk("n_mem_read", nrd, exp_rd);
        chk("n_mem_write", nwr, exp_wr);
        chk("done_latency", since, respond ? dly + 1 : TMO);
        chk("cpu_di", {24'd0, cpu_di}, {24'd0, exp_di});
        chk("bus_err", {31'd0, bus_err}, {31'd0, err_exp});
        chk("addr_stable", {31'd0, addr_ok}, 32'd1);
        $display("txn rd=%0b wr=%0b addr=%h do=%h dly=%0d resp=%0b -> di=%h err=%0b rd_pulses=%0d wr_pulses=%0d",
                 rd, wr, addr, data, dly, respond, cpu_di, bus_err, nrd, nwr);
        last_di = exp_di;

        cpu_read = 1'b0; cpu_write = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, cpu_ready}, 32'd1);
        chk("idle_quiet", {31'd0, mem_read | mem_write}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; cpu_addr = '0; cpu_do = '0; cpu_read = 1'b0; cpu_write = 1'b0;
        mem_ready = 1'b0; mem_data_read = '0; err_exp = 1'b0; last_di = 8'h00;

        // Reset state
        #23;
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_di", {24'd0, cpu_di}, 32'd0);
        chk("rst_addr", {14'd0, mem_address}, 32'd0);
        chk("rst_wdata", {16'd0, mem_data_write}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors
        mem[18'h00010] = 16'hBEEF;
        do_access(1'b1, 1'b0, 16'h0021, 8'h00, 1, 1'b1);
        mem[18'h00010] = 16'hBEEF;
        do_access(1'b0, 1'b1, 16'h0020, 8'h12, 2, 1'b1);
        do_access(1'b0, 1'b1, 16'h1234, 8'h5A, 1, 1'b1);
        do_access(1'b1, 1'b0, 16'h1234, 8'h00, 3, 1'b1);
        do_access(1'b1, 1'b1, 16'h0041, 8'hC3, 2, 1'b1);
        do_access(1'b1, 1'b0, 16'h0040, 8'h00, 1, 1'b1);
        do_access(1'b1, 1'b0, 16'h0040, 8'h00, 1, 1'b1);

        // Randomized accesses over a small address window
        for (int i = 0; i < 24; i++) begin
            logic r, w;
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            do_access(r, w, 16'h0100 + 16'($urandom_range(0, 11)), 8'($urandom),
                      $urandom_range(1, 5), 1'b1);
        end

        // mem_ready while idle must not start or finish anything
        @(negedge clk);
        mem_ready = 1'b1; mem_data_read = 16'h5AA5;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("stray_ready_quiet", {31'd0, mem_read | mem_write}, 32'd0);
        chk("stray_ready_idle", {31'd0, cpu_ready}, 32'd1);
        chk("stray_ready_di", {24'd0, cpu_di}, {24'd0, last_di});

        // Timeouts: read, then a write, then bus_err stays up on a good access
        do_access(1'b1, 1'b0, 16'h0300, 8'h00, 1, 1'b0);
        do_access(1'b0, 1'b1, 16'h0302, 8'h66, 1, 1'b0);
        do_access(1'b1, 1'b0, 16'h0021, 8'h00, 2, 1'b1);

        // Reset asserted during the first phase of a write
        @(negedge clk);
        cpu_addr = 16'h0020; cpu_do = 8'h77; cpu_write = 1'b1;
        @(negedge clk);
        chk("mid_strobe_seen", {31'd0, mem_read | mem_write}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("mid_rst_err", {31'd0, bus_err}, 32'd0);
        chk("mid_rst_di", {24'd0, cpu_di}, 32'd0);
        chk("mid_rst_addr", {14'd0, mem_address}, 32'd0);
        chk("mid_rst_wdata", {16'd0, mem_data_write}, 32'd0);
        cpu_write = 1'b0;
        #1 chk("mid_rst_idle", {31'd0, cpu_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        err_exp = 1'b0;
        last_di = 8'h00;
        do_access(1'b1, 1'b0, 16'h0000, 8'h00, 2, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_bus_bridge.md
SRAM_BUS_BRIDGE -- requirements
Module: sram_bus_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the memory-wait cycles before abort (range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock for all state.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port cpu_addr, input, 16 bits: CPU byte address, held stable while cpu_ready is low.
REQ-005 The block SHALL have port cpu_do, input, 8 bits: CPU write data.
REQ-006 The block SHALL have ports cpu_read and cpu_write, inputs, 1 bit each: level requests from the SoC RAM decode.
REQ-007 The block SHALL have port cpu_ready, output, 1 bit: drives the SoC ready input.
REQ-008 The block SHALL have port cpu_di, output, 8 bits: registered read data.
REQ-009 The block SHALL have port mem_address, output, 18 bits: SRAM controller word address.
REQ-010 The block SHALL have port mem_data_write, output, 16 bits: SRAM controller write data.
REQ-011 The block SHALL have ports mem_read and mem_write, outputs, 1 bit each: single-cycle active-high command strobes.
REQ-012 The block SHALL have port mem_ready, input, 1 bit: controller completion, high for one or more cycles.
REQ-013 The block SHALL have port mem_data_read, input, 16 bits: controller read data, valid while mem_ready is high.
REQ-014 The block SHALL have port bus_err, output, 1 bit: sticky timeout flag.

Function
REQ-015 The block SHALL implement states IDLE, RD, WR_RD, WR and DONE.
REQ-016 cpu_ready SHALL be combinationally high in IDLE with no request and in DONE, and low otherwise.
REQ-017 In IDLE, a request SHALL move the state to WR_RD when cpu_write=1 with packing enabled, to WR when cpu_write=1 with packing disabled, and to RD otherwise; write has priority over read.
REQ-018 Each state RD, WR_RD and WR SHALL pulse its strobe (mem_read for RD and WR_RD, mem_write for WR) for exactly its first cycle, then wait for mem_ready.
REQ-019 In RD, on mem_ready, the block SHALL register the selected byte lane into cpu_di and go to DONE; read latency is at least 3 cycles from request to DONE.
REQ-020 In WR_RD, on mem_ready, the block SHALL merge cpu_do into the addressed lane of mem_data_read, hold the merged word on mem_data_write, and go to WR.
REQ-021 In WR, on mem_ready, the block SHALL go to DONE.
REQ-022 DONE SHALL last exactly one cycle, then the state SHALL return to IDLE, so that back-to-back requests to the same address are distinct transactions.
REQ-023 A per-state wait counter SHALL clear on each strobe; if it reaches TIMEOUT_CYCLES without mem_ready, the block SHALL go to DONE with cpu_di=8'hFF (reads only), SHALL set bus_err, and SHALL issue no further strobe for that access.
REQ-024 mem_ready arriving while in IDLE or DONE SHALL be ignored.
REQ-025 mem_address and mem_data_write SHALL be stable from the strobe cycle until mem_ready.

Reset
REQ-026 While reset_n is low, the state SHALL be IDLE, mem_read=0, mem_write=0, cpu_di=8'h00, mem_address=0, mem_data_write=0, bus_err=0 and the counter=0, all asynchronously, including mid-transaction.
REQ-027 After reset release, the first request SHALL be sampled on the first rising clk edge.

Configuration
REQ-028 Macro SRAM_BRIDGE_PACKED_EN, when defined, SHALL select packed mapping: mem_address={3'b000,cpu_addr[15:1]}, lane=cpu_addr[0] (1=high byte), and byte writes by read-modify-write through WR_RD.
REQ-029 Without SRAM_BRIDGE_PACKED_EN, the block SHALL use linear mapping: mem_address={2'b00,cpu_addr}, mem_data_write={8'h00,cpu_do}, reads taking bits [7:0], WR_RD never entered, and the lane logic omitted.

Structure
REQ-030 The state encoding, the DONE read-fill value 8'hFF and the lane constants SHALL live in shared package sram_bridge_pkg.
REQ-031 The block SHALL be a single module with no sub-module; the timeout counter SHALL be inline.

Verification
REQ-032 Packed read: memory word 0x0010 = 16'hBEEF, read of 0x0021 -> mem_read pulse with mem_address=0x00010, cpu_di=8'hBE in DONE.
REQ-033 Packed write: word 0x0010 = 16'hBEEF, write 8'h12 to 0x0020 -> mem_read pulse then mem_write pulse with mem_data_write=16'hBE12.
REQ-034 Linear write: 8'h5A to 0x1234 -> a single mem_write pulse, mem_address=0x01234, mem_data_write=16'h005A, no mem_read.
REQ-035 Timeout: mem_ready held 0 with TIMEOUT_CYCLES=8 -> DONE 8 cycles after the strobe, cpu_di=8'hFF, bus_err=1 until reset.
REQ-036 Reset asserted in WR_RD -> strobes low and state IDLE immediately; after release, a read of 0x0000 completes normally.
REQ-037 Simultaneous cpu_read=1 and cpu_write=1 -> write path taken; two consecutive reads of 0x0040 -> two separate mem_read pulses.
